tt6581_pdm_out: RTL and testbench

TT6581_PDM_OUT -- requirements
Module: tt6581_pdm_out

---
 rtl/tt6581_pdm_out.sv | 66 ++++++
 tb/tb_tt6581_pdm_out.sv | 124 ++++++++++++
 2 files changed

// File: rtl/tt6581_pdm_out.sv
// tt6581_pdm_out: 2-entry sample FIFO feeding a first-order delta-sigma PDM modulator
module tt6581_pdm_out #(
  parameter int DW  = 14,
  parameter int DIV = 4,
  parameter int OSR = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          underrun_clr,
  output logic          pdm_out,
  output logic          underrun,
  output logic [1:0]    fill
);
  localparam int TW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int SW = OSR > 1 ? $clog2(OSR) : 1;
  logic [TW-1:0] tick_q;
  logic [SW-1:0] smp_q;
  logic [DW-1:0] mem0_q, mem1_q, mem0_d, mem1_d, act_q, acc_q, u;
  logic [1:0]    fill_q, fill_d, wr;
  logic          pdm_q, und_q, bit_tick, sample_due, push, pop;
  logic [DW:0]   sum;
  assign bit_tick   = tick_q == TW'(DIV - 1);
  assign sample_due = bit_tick && smp_q == SW'(OSR - 1);
  assign s_ready    = fill_q != 2'd2;
  assign push       = s_valid && s_ready;
  assign pop        = sample_due && fill_q != 2'd0;
  assign u          = {~act_q[DW-1], act_q[DW-2:0]};
  assign sum        = {1'b0, acc_q} + {1'b0, u};
  assign pdm_out    = pdm_q;
  assign underrun   = und_q;
  assign fill       = fill_q;
  // a pop shifts the tail to the head before any push lands in the freed slot
  always_comb begin
    wr     = fill_q - {1'b0, pop};
    fill_d = wr + {1'b0, push};
    mem0_d = push && wr == 2'd0 ? s_data : pop ? mem1_q : mem0_q;
    mem1_d = push && wr == 2'd1 ? s_data : mem1_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q <= '0;
      smp_q  <= '0;
      fill_q <= '0;
      mem0_q <= '0;
      mem1_q <= '0;
      act_q  <= '0;
      acc_q  <= '0;
      pdm_q  <= 1'b0;
      und_q  <= 1'b0;
    end else begin
      tick_q <= bit_tick ? '0 : tick_q + 1'b1;
      if (bit_tick) begin
        smp_q          <= sample_due ? '0 : smp_q + 1'b1;
        {pdm_q, acc_q} <= sum;
      end
      fill_q <= fill_d;
      mem0_q <= mem0_d;
      mem1_q <= mem1_d;
      if (pop) act_q <= mem0_q;
      und_q <= (sample_due && fill_q == 2'd0) ? 1'b1 : underrun_clr ? 1'b0 : und_q;
    end
  end
endmodule

// File: tb/tb_tt6581_pdm_out.sv
// tb_tt6581_pdm_out: random and directed stimulus checked cycle by cycle against a queue/arithmetic model
module tb_tt6581_pdm_out;
  localparam int DW = 10, DIV = 4, OSR = 4;
  logic clk = 0, rst = 1, s_valid = 0, underrun_clr = 0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, pdm_out, underrun;
  logic [1:0] fill;
  int n_chk = 0, n_err = 0;
  logic signed [DW-1:0] mq[$];
  logic signed [DW-1:0] m_act;
  int m_cyc, m_ticks, m_acc, ones;
  bit m_pdm, m_und, last_bt;

  tt6581_pdm_out #(.DW(DW), .DIV(DIV), .OSR(OSR)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .underrun_clr(underrun_clr), .pdm_out(pdm_out), .underrun(underrun), .fill(fill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit due_now();
    return (m_cyc % DIV == DIV - 1) && (m_ticks % OSR == OSR - 1);
  endfunction

  task automatic step();
    bit bt, due, pushed;
    int u, s;
    bt = m_cyc % DIV == DIV - 1;
    due = due_now();
    pushed = s_valid && mq.size() != 2;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_act = 0; m_acc = 0; m_pdm = 0; m_und = 0; m_cyc = 0; m_ticks = 0;
      last_bt = 0;
    end else begin
      u = int'(m_act) + 2 ** (DW - 1);
      if (bt) begin
        s = m_acc + u;
        m_pdm = s >= 2 ** DW;
        m_acc = s % (2 ** DW);
      end
      if (due && mq.size() == 0) m_und = 1;
      else if (underrun_clr) m_und = 0;
      if (due && mq.size() > 0) m_act = mq.pop_front();
      if (pushed) mq.push_back(s_data);
      m_cyc++;
      if (bt) m_ticks++;
      last_bt = bt;
    end
    #1;
    chk("pdm", pdm_out, m_pdm);
    chk("fill", fill, mq.size());
    chk("und", underrun, m_und);
    chk("rdy", s_ready, mq.size() != 2);
  endtask

  task automatic do_reset(input int n);
    rst = 1; s_valid = 0; underrun_clr = 0;
    repeat (n) step();
    rst = 0;
  endtask

  task automatic density(input logic [DW-1:0] d, input int exp, input string tag);
    int n;
    do_reset(1);
    s_valid = 1; s_data = d;
    for (int i = 0; i < 4 * DIV * OSR && m_ticks < OSR; i++) step();
    ones = 0; n = 0;
    for (int i = 0; i < 2 * DIV * (2 ** DW) && n < 2 ** DW; i++) begin
      step();
      if (last_bt) begin ones += pdm_out; n++; end
    end
    chk(tag, ones, exp);
    s_valid = 0;
  endtask

  initial begin
    do_reset(3);
    chk("rst_pdm", pdm_out, 0);
    chk("rst_fill", fill, 0);
    chk("rst_und", underrun, 0);
    chk("rst_rdy", s_ready, 1);
    // midscale idle stream and first underrun
    repeat (DIV * OSR + 2) step();
    chk("und_set", underrun, 1);
    underrun_clr = 1; step(); underrun_clr = 0;
    chk("und_clr", underrun, 0);
    for (int i = 0; i < DIV * OSR && !due_now(); i++) step();
    underrun_clr = 1; step(); underrun_clr = 0;
    chk("und_prio", underrun, 1);
    // backpressure: three back-to-back pushes, no pop due yet
    do_reset(1);
    s_valid = 1;
    for (int i = 0; i < 3; i++) begin s_data = DW'(100 + i); step(); end
    chk("bp_fill", fill, 2);
    chk("bp_rdy", s_ready, 0);
    for (int i = 0; i < 2 * DIV * OSR && mq.size() == 2; i++) step();
    s_valid = 0;
    repeat (3 * DIV * OSR) step();
    density(DW'(2 ** (DW - 1) - 1), 2 ** DW - 1, "dens_hi");
    density(DW'(2 ** (DW - 1)), 0, "dens_lo");
    // random traffic with occasional mid-stream resets
    do_reset(1);
    for (int i = 0; i < 4000; i++) begin
      s_valid = $urandom_range(0, 3) == 0;
      s_data = DW'($urandom);
      underrun_clr = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 499) == 0;
      step();
    end
    rst = 0; s_valid = 0; underrun_clr = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
